// File: rtl/demux_1to4_driver.sv
// ---------------------------------------------------------------------------------------------
// demux_1to4_driver
//
// Sequential front-end for a combinational 1-to-4 demultiplexer. Items of the form
// {destination, data-bit} arrive over a valid/ready handshake and are buffered in a small FIFO.
// Each item is then presented to the demux in a glitch-safe way:
//   1. SETUP: the selects {s1,s0} move to the new destination while I is held at 0.
//   2. DRIVE: I carries the data bit for HOLD_CYCLES cycles with the selects stable.
// Because I is 0 whenever the selects change, the demux outputs y0..y3 only ever see clean,
// full-width pulses.
//
// All demux-facing outputs (I, s1, s0) are registered. They lag the FSM state by one cycle, so
// the selects become valid on the edge after the FSM enters SETUP.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   HOLD_CYCLES  cycles I is driven per item (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     item offered
//   in_ready     FIFO can accept (occupancy < DEPTH); depends on occupancy only
//   in_dest      destination channel {s1,s0}
//   in_data      bit to deliver
//   I            data to demux (registered)
//   s1, s0       selects to demux (registered)
//   busy         FSM not idle or FIFO non-empty
//   fifo_count   current FIFO occupancy
//   err_drop     sticky; set when an item is offered while in_ready is low
//   ch_cnt       (only with DEMUX_DRV_CNT_EN) four saturating 8-bit per-channel counts of
//                delivered 1-bits; channel n lives in bits [8n+7:8n]
//
// Optional feature macro: DEMUX_DRV_CNT_EN (adds ch_cnt and its counters).
// ---------------------------------------------------------------------------------------------
module demux_1to4_driver #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   localparam int unsigned AW         = $clog2(DEPTH),
   localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_dest,
   input  logic          in_data,
   output logic          I,
   output logic          s1,
   output logic          s0,
   output logic          busy,
   output logic [CW-1:0] fifo_count,
`ifdef DEMUX_DRV_CNT_EN
   output logic          err_drop,
   output logic [31:0]   ch_cnt
`else
   output logic          err_drop
`endif
);

   // Hold counter must represent HOLD_CYCLES-1; keep at least one bit.
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [CW-1:0] FullCount = CW'(DEPTH);
   localparam logic [HW-1:0] HoldLoad  = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StDrive
   } state_e;

   // ------------------------------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------------------------------
   // Entry layout: {dest[1:0], data}
   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [2:0]    rd_data;

   assign fifo_empty = (count_q == '0);
   assign in_ready   = (count_q != FullCount);
   assign push       = in_valid && in_ready;
   assign rd_data    = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_dest, in_data};
      end
   end

   // ------------------------------------------------------------------------------------------
   // Delivery FSM
   // ------------------------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [2:0]    cur_q, cur_d;     // item being delivered, {dest, data}
   logic          i_q, i_d;
   logic [1:0]    sel_q, sel_d;
   logic          err_q, err_d;
   logic          last_drive;       // final DRIVE cycle of the current item

   assign last_drive = (state_q == StDrive) && (hold_q == '0);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cur_d   = cur_q;
      sel_d   = sel_q;
      i_d     = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cur_d   = rd_data;
               state_d = StSetup;
            end
         end
         StSetup: begin
            // Selects move while I is forced low; the data phase starts next cycle.
            sel_d   = cur_q[2:1];
            hold_d  = HoldLoad;
            state_d = StDrive;
         end
         StDrive: begin
            i_d = cur_q[0];
            if (hold_q == '0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  cur_d   = rd_data;
                  state_d = StSetup;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Dropped offers are flagged but never stored.
   always_comb begin
      err_d = err_q;
      if (in_valid && !in_ready) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         hold_q  <= '0;
         cur_q   <= '0;
         i_q     <= 1'b0;
         sel_q   <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cur_q   <= cur_d;
         i_q     <= i_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   assign I          = i_q;
   assign s1         = sel_q[1];
   assign s0         = sel_q[0];
   assign busy       = (state_q != StIdle) || !fifo_empty;
   assign fifo_count = count_q;
   assign err_drop   = err_q;

   // ------------------------------------------------------------------------------------------
   // Optional per-channel delivery counters
   // ------------------------------------------------------------------------------------------
`ifdef DEMUX_DRV_CNT_EN
   logic [7:0] cnt_q [4];
   logic [7:0] cnt_d [4];

   // A 1-bit counts once, on the last DRIVE cycle of its item.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         cnt_d[n] = cnt_q[n];
         if (last_drive && cur_q[0] && (cur_q[2:1] == 2'(n)) && (cnt_q[n] != 8'hFF)) begin
            cnt_d[n] = cnt_q[n] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= 8'd0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

   assign ch_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   logic unused_last_drive;
   assign unused_last_drive = last_drive;
`endif

   // ------------------------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------------------------
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !fifo_empty);

   a_no_glitch: assert property (@(posedge clk) disable iff (rst)
                                 (sel_q != $past(sel_q)) |-> !i_q);

endmodule

// File: tb/tb_demux_1to4_driver.sv
// ---------------------------------------------------------------------------------------------
// Bench for demux_1to4_driver. A timeline model tracks each item from the edge it is popped:
// one edge later the selects show its destination, the next HOLD edges show its data on I, and
// the FIFO may release the next item on the edge the hold expires. Every cycle the DUT outputs
// are compared against the model at the falling edge; a few literal expectations pin the
// model to hand-worked timings.
// ---------------------------------------------------------------------------------------------
module tb_demux_1to4_driver;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_dest;
   logic          in_data;
   logic          I;
   logic          s1;
   logic          s0;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          err_drop;
`ifdef DEMUX_DRV_CNT_EN
   logic [31:0]   ch_cnt;
`endif

   demux_1to4_driver #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_data    (in_data),
      .I          (I),
      .s1         (s1),
      .s0         (s0),
      .busy       (busy),
      .fifo_count (fifo_count),
`ifdef DEMUX_DRV_CNT_EN
      .err_drop   (err_drop),
      .ch_cnt     (ch_cnt)
`else
      .err_drop   (err_drop)
`endif
   );

   always #5 clk = ~clk;

   // Model state
   logic [2:0] mq[$];        // buffered items {dest, data}
   bit         m_active;     // an item has been popped and is not yet finished
   int         m_age;        // edges since that item was popped
   logic [2:0] m_cur;
   logic [1:0] m_sel;
   logic       m_i;
   logic       m_err;
   int         m_cnt[4];

   int         n_vec = 0;
   int         n_err = 0;
   logic [1:0] prev_sel;
   int         y_cnt[4];     // I=1 cycles seen on each demux output
   bit         saw_full;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_cur    = '0;
      m_sel    = 2'b00;
      m_i      = 1'b0;
      m_err    = 1'b0;
      prev_sel = 2'b00;
      for (int n = 0; n < 4; n++) begin
         m_cnt[n] = 0;
      end
   endtask

   // Advance the model across one rising edge, using the inputs present at that edge.
   task automatic model_step();
      int sz;
      int a;
      bit act;
      bit ready;
      sz    = mq.size();
      a     = m_age;
      act   = m_active;
      ready = (sz < DEPTH);
      m_i   = 1'b0;
      if (act && a == 0) m_sel = m_cur[2:1];
      if (act && a >= 1 && a <= HOLD) m_i = m_cur[0];
      if (act && a == HOLD && m_cur[0] && m_cnt[m_cur[2:1]] < 255) m_cnt[m_cur[2:1]]++;
      if (sz > 0 && (!act || a == HOLD)) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_age    = 0;
      end else if (act && a == HOLD) begin
         m_active = 1'b0;
      end else if (act) begin
         m_age = a + 1;
      end
      if (in_valid) begin
         if (ready) mq.push_back({in_dest, in_data});
         else m_err = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("I", I, m_i);
      chk("sel", {s1, s0}, m_sel);
      chk("fifo_count", fifo_count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("busy", busy, m_active || mq.size() > 0);
      chk("err_drop", err_drop, m_err);
      chk("glitch", (I === 1'b1) && ({s1, s0} !== prev_sel), 1'b0);
`ifdef DEMUX_DRV_CNT_EN
      for (int n = 0; n < 4; n++) begin
         chk("ch_cnt", ch_cnt[8*n +: 8], m_cnt[n]);
      end
`endif
      if (I === 1'b1) y_cnt[{s1, s0}]++;
      if (fifo_count == DEPTH && !in_ready) saw_full = 1'b1;
      prev_sel = {s1, s0};
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_I"}, I, 1'b0);
      chk({name, "_sel"}, {s1, s0}, 2'b00);
      chk({name, "_count"}, fifo_count, 0);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_err"}, err_drop, 1'b0);
   endtask

   // Asynchronous reset asserted between edges; called at a falling edge.
   task automatic async_reset(input string name);
      #2 rst = 1'b1;
      #1 check_all_zero(name);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();
   endtask

   // Offer items only while the model says the FIFO has room, so none are dropped.
   task automatic push_items(input int n, input bit rnd, input logic [1:0] d, input logic v);
      int pushed;
      pushed = 0;
      while (pushed < n) begin
         in_valid = (mq.size() < DEPTH);
         in_dest  = rnd ? 2'($urandom_range(3)) : d;
         in_data  = rnd ? 1'($urandom_range(1)) : v;
         if (in_valid) pushed++;
         cycle();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      in_dest  = 2'd3;
      in_data  = 1'b1;
      saw_full = 1'b0;
      for (int n = 0; n < 4; n++) y_cnt[n] = 0;
      model_reset();

      // Reset held with an offer present: everything stays cleared.
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      chk("reset_ready", in_ready, 1'b1);
      rst = 1'b0;
      #1 chk("ready_after_reset", in_ready, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check_all();

      // Single item dest=2 data=1 pushed at edge T.
      in_valid = 1'b1;
      in_dest  = 2'd2;
      in_data  = 1'b1;
      cycle();                                   // edge T
      in_valid = 1'b0;
      cycle();                                   // T+1
      cycle();                                   // T+2
      chk("single_T2_sel", {s1, s0}, 2'b10);
      chk("single_T2_I", I, 1'b0);
      cycle();                                   // T+3
      chk("single_T3_I", I, 1'b1);
      cycle();                                   // T+4
      chk("single_T4_I", I, 1'b1);
      cycle();                                   // T+5
      chk("single_T5_I", I, 1'b0);
      chk("single_T5_busy", busy, 1'b0);

      // Back-to-back items to every channel.
      for (int n = 0; n < 4; n++) y_cnt[n] = 0;
      for (int n = 0; n < 4; n++) begin
         in_valid = 1'b1;
         in_dest  = 2'(n);
         in_data  = 1'b1;
         cycle();
      end
      idle_cycles(16);
      for (int n = 0; n < 4; n++) chk("pulse_width", y_cnt[n], HOLD);

      // Continuous offers overrun the FIFO.
      for (int k = 0; k < 12; k++) begin
         in_valid = 1'b1;
         in_dest  = 2'($urandom_range(3));
         in_data  = 1'($urandom_range(1));
         cycle();
      end
      chk("saw_full", saw_full, 1'b1);
      chk("drop_flag", err_drop, 1'b1);
      idle_cycles(16);

      // Reset in the middle of a DRIVE phase.
      async_reset("mid_reset_prep");
      in_valid = 1'b1;
      in_dest  = 2'd3;
      in_data  = 1'b1;
      cycle();
      in_valid = 1'b1;
      in_dest  = 2'd1;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      chk("pre_reset_I", I, 1'b1);
      async_reset("mid_drive");

      // Ten items through two pointer wraps, then a long random run.
      push_items(10, 1'b1, 2'd0, 1'b0);
      idle_cycles(40);
      for (int k = 0; k < 1500; k++) begin
         in_valid = ($urandom_range(99) < 40);
         in_dest  = 2'($urandom_range(3));
         in_data  = 1'($urandom_range(1));
         cycle();
      end
      idle_cycles(40);

`ifdef DEMUX_DRV_CNT_EN
      async_reset("cnt_prep");
      push_items(300, 1'b0, 2'd3, 1'b1);
      push_items(5, 1'b0, 2'd3, 1'b0);
      push_items(5, 1'b0, 2'd1, 1'b0);
      idle_cycles(40);
      chk("ch_cnt_sat", ch_cnt, 32'hFF00_0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
